// File: rtl/scan_chain_controller.sv
// scan_chain_controller
//   Initiator for an external serial scan chain. Shifts a parallel pattern into
//   the chain MSB-first while collecting the chain's previous contents. In
//   capture mode it then pulses one functional-capture cycle and unloads the
//   captured value, leaving the chain all-zero.
//
//   State table
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start; pattern/mode latched on start
//   SHIFT    | CHAIN_LEN cycles: pattern MSB -> scan_in, scan_out -> result
//   CAPTURE  | one cycle with chain_enable: chain loads functional data
//   UNLOAD   | CHAIN_LEN cycles: zeros -> scan_in, scan_out -> result
//   DONE     | one-cycle done pulse; unload_data updated on entry
//
//   Ports
//   clk, rst       clock, synchronous active-high reset
//   start          begin operation (sampled only in IDLE)
//   do_capture     with start: 1 = load, capture, unload
//   load_data      pattern to shift in (sampled with start)
//   busy, done     status; done is a one-cycle pulse
//   unload_data    data shifted out of the chain, held until the next DONE
//   scan_enable    chain shift enable
//   scan_in        serial data into chain LSB
//   chain_enable   chain functional-capture enable
//   scan_out       chain MSB
module scan_chain_controller #(
   parameter int CHAIN_LEN = 3,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 do_capture,
   input  logic [CHAIN_LEN-1:0] load_data,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] unload_data,
   output logic                 scan_enable,
   output logic                 scan_in,
   output logic                 chain_enable,
   input  logic                 scan_out
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   state_t               state_q, state_d;
   logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
   logic [CHAIN_LEN-1:0] result_q, result_d;
   logic [CHAIN_LEN-1:0] unload_data_q, unload_data_d;
   logic                 mode_q, mode_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 scan_enable_q, scan_enable_d;
   logic                 scan_in_q, scan_in_d;
   logic                 chain_enable_q, chain_enable_d;
   logic                 cnt_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         pattern_q      <= '0;
         result_q       <= '0;
         unload_data_q  <= '0;
         mode_q         <= 1'b0;
         cnt_q          <= '0;
         scan_enable_q  <= 1'b0;
         scan_in_q      <= 1'b0;
         chain_enable_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pattern_q      <= pattern_d;
         result_q       <= result_d;
         unload_data_q  <= unload_data_d;
         mode_q         <= mode_d;
         cnt_q          <= cnt_d;
         scan_enable_q  <= scan_enable_d;
         scan_in_q      <= scan_in_d;
         chain_enable_q <= chain_enable_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pattern_d      = pattern_q;
      result_d       = result_q;
      unload_data_d  = unload_data_q;
      mode_d         = mode_q;
      cnt_d          = cnt_q;
      scan_enable_d  = 1'b0;
      scan_in_d      = 1'b0;
      chain_enable_d = 1'b0;
      cnt_last       = (cnt_q == CNT_LAST);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               pattern_d = load_data;
               mode_d    = do_capture;
               cnt_d     = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            pattern_d = {pattern_q[CHAIN_LEN-2:0], 1'b0};
            result_d  = {result_q[CHAIN_LEN-2:0], scan_out};
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = mode_q ? ST_CAPTURE : ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            cnt_d   = '0;
            state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            result_d = {result_q[CHAIN_LEN-2:0], scan_out};
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The last scan_out bit lands in result on the same edge that enters
      // DONE, so capture the updated value to have it valid during done.
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         unload_data_d = result_d;
      end

      // Chain controls are registered from the next state so they line up
      // with the cycle the FSM is in.
      scan_enable_d  = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
      scan_in_d      = (state_d == ST_SHIFT) ? pattern_d[CHAIN_LEN-1] : 1'b0;
      chain_enable_d = (state_d == ST_CAPTURE);
   end

   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign unload_data  = unload_data_q;
   assign scan_enable  = scan_enable_q;
   assign scan_in      = scan_in_q;
   assign chain_enable = chain_enable_q;

endmodule
